scpu_test_seq: RTL and testbench
================================

SCPU_TEST_SEQ -- requirements
Module: scpu_test_seq

Parameters
REQ-001 DATA_W, default 32, width of instruction, data-in and register-result words.
REQ-002 IDX_W, default 5, width of register-index field.
REQ-003 N_VEC, default 32, vector table depth (2..256); AW = clog2(N_VEC), CW = clog2(N_VEC+1).
REQ-004 STEP_CYC, default 2, clock cycles per vector (2..15).

Interface
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high; sampled on rising edge of clk.
REQ-007 vec_we  in  1  write strobe for vector table.
REQ-008 vec_addr  in  AW  table entry written.
REQ-009 vec_inst / vec_din / vec_exp  in  DATA_W each  instruction, data word, expected register value.
REQ-010 vec_idx  in  IDX_W  register index to observe; vec_chk  in  1  compare enable for entry.
REQ-011 start  in  1  run request; run_len  in  CW  number of vectors to execute.
REQ-012 test_reg_result  in  DATA_W  register value returned by CPU under test.
REQ-013 inst_out / data_out  out  DATA_W  registered instruction and data words to CPU.
REQ-014 test_reg_index  out  IDX_W  registered register-index select to CPU.
REQ-015 busy, done, fail_flag  out  1 each  status.
REQ-016 pass_cnt, fail_cnt  out  CW each  checked-vector outcome counts.
REQ-017 first_fail  out  AW  index of first failing vector.

Function
REQ-018 FSM states IDLE, STEP, DONE; busy = 1 only in STEP; done = 1 only in DONE.
REQ-019 Table write on vec_we in IDLE or DONE: all five fields stored at vec_addr next edge; vec_we in STEP ignored; vec_addr >= N_VEC ignored.
REQ-020 IDLE/DONE + start: len = min(run_len, N_VEC) latched; len = 0 -> DONE next cycle, counts cleared; else STEP with k = 0, counts/fail_flag/first_fail cleared.
REQ-021 start while in STEP ignored.
REQ-022 Entering vector k (cycle 0 of step): inst_out, data_out, test_reg_index load entry k on same edge; held for exactly STEP_CYC cycles.
REQ-023 Step cycle counter counts 0..STEP_CYC-1; check occurs on edge ending cycle STEP_CYC-1.
REQ-024 Check: chk=1 and test_reg_result == exp -> pass_cnt+1; chk=1 and mismatch -> fail_cnt+1, fail_flag set; chk=0 -> no count change.
REQ-025 First mismatch of a run loads first_fail = k; later mismatches leave it unchanged.
REQ-026 After checking k = len-1: DONE, inst_out/data_out forced to 0 (nop), test_reg_index held; otherwise k+1 loaded.
REQ-027 DONE persists, outputs stable, until start or reset; DONE + start restarts per REQ-020.
REQ-028 Counters never wrap: max count N_VEC fits CW bits.

Reset
REQ-029 reset in any state, including mid-run: next edge -> IDLE, inst_out = data_out = 0, test_reg_index = 0, busy = done = fail_flag = 0, pass_cnt = fail_cnt = 0, first_fail = 0.
REQ-030 Table contents not cleared by reset; reset dominates start and vec_we in same cycle.

Verification
REQ-031 Load 3 entries (addi 0x20210001 idx1 exp1; add 0x00211020 idx2 exp2; ori 0x34630003 idx3 exp3), all chk=1, model returns exp, start run_len=3 -> inst_out each held 2 cycles, done after 6 cycles, pass_cnt=3, fail_cnt=0, fail_flag=0.
REQ-032 Same run, model returns 0 on vector 1 only -> pass_cnt=2, fail_cnt=1, first_fail=1, fail_flag=1.
REQ-033 run_len=0 -> done next cycle, busy never asserted, counts 0; run_len=N_VEC+5 -> exactly N_VEC vectors stepped.
REQ-034 Assert reset during vector 1 of 3-vector run -> IDLE next edge, all outputs zero; restart run_len=3 -> entries intact, pass_cnt=3.
REQ-035 start and vec_we pulsed during STEP -> no restart, table entry unchanged; chk=0 entry with mismatching result -> no count change.

Source files
------------

// File: rtl/scpu_test_seq.sv
// scpu_test_seq: vector-table driven test sequencer for a small CPU.
// A table of (instruction, data, register index, expected value, check
// enable) entries is loaded while idle. A run then presents each entry to
// the CPU for STEP_CYC cycles. It compares the returned register value at
// the end of each step and accumulates pass/fail statistics.
module scpu_test_seq #(
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 5,
    parameter int N_VEC    = 32,
    parameter int STEP_CYC = 2,
    localparam int AW      = $clog2(N_VEC),
    localparam int CW      = $clog2(N_VEC + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vec_we,
    input  logic [AW-1:0]     vec_addr,
    input  logic [DATA_W-1:0] vec_inst,
    input  logic [DATA_W-1:0] vec_din,
    input  logic [DATA_W-1:0] vec_exp,
    input  logic [IDX_W-1:0]  vec_idx,
    input  logic              vec_chk,
    input  logic              start,
    input  logic [CW-1:0]     run_len,
    input  logic [DATA_W-1:0] test_reg_result,
    output logic [DATA_W-1:0] inst_out,
    output logic [DATA_W-1:0] data_out,
    output logic [IDX_W-1:0]  test_reg_index,
    output logic              busy,
    output logic              done,
    output logic              fail_flag,
    output logic [CW-1:0]     pass_cnt,
    output logic [CW-1:0]     fail_cnt,
    output logic [AW-1:0]     first_fail
);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;

    localparam logic [CW-1:0] NVEC_C   = CW'(N_VEC);
    localparam logic [3:0]    LAST_CYC = 4'(STEP_CYC - 1);

    // Vector table; deliberately outside the reset domain so a reset keeps it.
    logic [DATA_W-1:0] inst_mem [N_VEC];
    logic [DATA_W-1:0] din_mem  [N_VEC];
    logic [DATA_W-1:0] exp_mem  [N_VEC];
    logic [IDX_W-1:0]  idx_mem  [N_VEC];
    logic              chk_mem  [N_VEC];

    state_t            state_q, state_d;
    logic [CW-1:0]     len_q, len_d;
    logic [AW-1:0]     k_q, k_d;
    logic [3:0]        cyc_q, cyc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              flag_q, flag_d;
    logic [CW-1:0]     pass_q, pass_d;
    logic [CW-1:0]     fail_q, fail_d;
    logic [AW-1:0]     ff_q, ff_d;

    logic              addr_ok;
    logic [CW-1:0]     start_len;
    logic [AW-1:0]     k_nxt;

    // Addresses beyond the table only exist when N_VEC is not a power of two.
    generate
        if ((1 << AW) == N_VEC) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = ({1'b0, vec_addr} < {1'b0, AW'(N_VEC)});
        end
    endgenerate

    assign start_len = (run_len > NVEC_C) ? NVEC_C : run_len;
    assign k_nxt     = k_q + AW'(1);

    // Table write: only outside a run, and reset has priority.
    always_ff @(posedge clk) begin
        if (!reset && vec_we && addr_ok && (state_q != S_STEP)) begin
            inst_mem[vec_addr] <= vec_inst;
            din_mem[vec_addr]  <= vec_din;
            exp_mem[vec_addr]  <= vec_exp;
            idx_mem[vec_addr]  <= vec_idx;
            chk_mem[vec_addr]  <= vec_chk;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            k_q     <= '0;
            cyc_q   <= '0;
            inst_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            flag_q  <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            k_q     <= k_d;
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            flag_q  <= flag_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ff_q    <= ff_d;
        end
    end

    // Next-state: run launch, per-step cycle count, end-of-step check/advance.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        k_d     = k_q;
        cyc_d   = cyc_q;
        inst_d  = inst_q;
        data_d  = data_q;
        idx_d   = idx_q;
        flag_d  = flag_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        ff_d    = ff_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d  = start_len;
                    k_d    = '0;
                    cyc_d  = '0;
                    pass_d = '0;
                    fail_d = '0;
                    flag_d = 1'b0;
                    ff_d   = '0;
                    if (start_len == '0) begin
                        // Empty run: straight to DONE with nop on the bus.
                        state_d = S_DONE;
                        inst_d  = '0;
                        data_d  = '0;
                    end else begin
                        state_d = S_STEP;
                        inst_d  = inst_mem[0];
                        data_d  = din_mem[0];
                        idx_d   = idx_mem[0];
                    end
                end
            end
            S_STEP: begin
                if (cyc_q == LAST_CYC) begin
                    if (chk_mem[k_q]) begin
                        if (test_reg_result == exp_mem[k_q]) begin
                            pass_d = pass_q + CW'(1);
                        end else begin
                            fail_d = fail_q + CW'(1);
                            flag_d = 1'b1;
                            // flag_q still low means this is the run's first miss.
                            if (!flag_q) ff_d = k_q;
                        end
                    end
                    if (CW'(k_q) == (len_q - CW'(1))) begin
                        state_d = S_DONE;
                        inst_d  = '0;
                        data_d  = '0;
                    end else begin
                        k_d    = k_nxt;
                        cyc_d  = '0;
                        inst_d = inst_mem[k_nxt];
                        data_d = din_mem[k_nxt];
                        idx_d  = idx_mem[k_nxt];
                    end
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign inst_out       = inst_q;
    assign data_out       = data_q;
    assign test_reg_index = idx_q;
    assign busy           = (state_q == S_STEP);
    assign done           = (state_q == S_DONE);
    assign fail_flag      = flag_q;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign first_fail     = ff_q;

endmodule

// File: tb/tb_scpu_test_seq.sv
// Directed bench for scpu_test_seq (defaults: 32-bit, 32 vectors, 2 cycles/step).
// The CPU model answers with the observed register index, so an entry whose
// expected value equals its index passes; bad_idx forces one index to read 0.
module tb_scpu_test_seq;

    localparam int AW = 5;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          vec_we;
    logic [AW-1:0] vec_addr;
    logic [31:0]   vec_inst, vec_din, vec_exp;
    logic [4:0]    vec_idx;
    logic          vec_chk;
    logic          start;
    logic [CW-1:0] run_len;
    logic [31:0]   test_reg_result;
    logic [31:0]   inst_out, data_out;
    logic [4:0]    test_reg_index;
    logic          busy, done, fail_flag;
    logic [CW-1:0] pass_cnt, fail_cnt;
    logic [AW-1:0] first_fail;

    int errors = 0;
    int checks = 0;
    logic       bad_on;
    logic [4:0] bad_idx;

    logic [31:0] ti [3];
    logic [31:0] td [3];

    always #5 clk = ~clk;

    always_comb begin
        test_reg_result = {27'b0, test_reg_index};
        if (bad_on && test_reg_index == bad_idx) test_reg_result = 32'h0;
    end

    scpu_test_seq dut (
        .clk(clk), .reset(reset), .vec_we(vec_we), .vec_addr(vec_addr),
        .vec_inst(vec_inst), .vec_din(vec_din), .vec_exp(vec_exp),
        .vec_idx(vec_idx), .vec_chk(vec_chk), .start(start), .run_len(run_len),
        .test_reg_result(test_reg_result), .inst_out(inst_out),
        .data_out(data_out), .test_reg_index(test_reg_index), .busy(busy),
        .done(done), .fail_flag(fail_flag), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .first_fail(first_fail)
    );

    task automatic write_vec(input int a, input logic [31:0] inst, input logic [31:0] din,
                             input logic [31:0] exp, input logic [4:0] idx, input logic chk);
        @(negedge clk);
        vec_we = 1'b1; vec_addr = AW'(a); vec_inst = inst; vec_din = din;
        vec_exp = exp; vec_idx = idx; vec_chk = chk;
        @(negedge clk);
        vec_we = 1'b0;
    endtask

    // Returns at the sample point of step cycle 0 of the first vector.
    task automatic start_run(input int len);
        @(negedge clk);
        start = 1'b1; run_len = CW'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy samples until done; an expired budget is a failure.
    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            if (busy) n++;
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_done: done=%0b after %0d cycles, required done=1", done, n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({inst_out, data_out} !== 64'h0 || test_reg_index !== 5'd0 ||
            {busy, done, fail_flag} !== 3'b000 || pass_cnt !== 0 || fail_cnt !== 0 ||
            first_fail !== 0) begin
            errors++;
            $display("FAIL reset_state: inst=%h data=%h idx=%0d b/d/f=%b%b%b p=%0d f=%0d ff=%0d, required all 0",
                     inst_out, data_out, test_reg_index, busy, done, fail_flag,
                     pass_cnt, fail_cnt, first_fail);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_run;
        int n;
        for (int i = 0; i < 3; i++)
            write_vec(i, ti[i], td[i], 32'(i + 1), 5'(i + 1), 1'b1);
        start_run(3);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (inst_out !== ti[c/2] || data_out !== td[c/2] ||
                test_reg_index !== 5'(c/2 + 1) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_step c%0d: inst=%h data=%h idx=%0d busy=%0b done=%0b, required %h %h %0d 1 0",
                         c, inst_out, data_out, test_reg_index, busy, done,
                         ti[c/2], td[c/2], c/2 + 1);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || inst_out !== 0 || data_out !== 0 ||
            test_reg_index !== 5'd3) begin
            errors++;
            $display("FAIL basic_done: done=%0b busy=%0b inst=%h data=%h idx=%0d, required 1 0 0 0 3",
                     done, busy, inst_out, data_out, test_reg_index);
        end
        checks++;
        if (pass_cnt !== 6'd3 || fail_cnt !== 6'd0 || fail_flag !== 1'b0) begin
            errors++;
            $display("FAIL basic_counts: pass=%0d fail=%0d flag=%0b, required 3 0 0",
                     pass_cnt, fail_cnt, fail_flag);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || inst_out !== 0 || pass_cnt !== 6'd3) begin
            errors++;
            $display("FAIL done_hold: done=%0b inst=%h pass=%0d, required 1 0 3",
                     done, inst_out, pass_cnt);
        end
    endtask

    task automatic test_fail_vec;
        int n;
        bad_on = 1'b1; bad_idx = 5'd2;
        start_run(3);
        wait_done(20, n);
        checks++;
        if (pass_cnt !== 6'd2 || fail_cnt !== 6'd1 || first_fail !== 5'd1 || fail_flag !== 1'b1) begin
            errors++;
            $display("FAIL fail_vec: pass=%0d fail=%0d ff=%0d flag=%0b, required 2 1 1 1",
                     pass_cnt, fail_cnt, first_fail, fail_flag);
        end
        bad_on = 1'b0;
    endtask

    task automatic test_zero_len;
        start_run(0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass_cnt !== 0 || fail_cnt !== 0 ||
            fail_flag !== 1'b0 || first_fail !== 0) begin
            errors++;
            $display("FAIL zero_len: done=%0b busy=%0b pass=%0d fail=%0d flag=%0b ff=%0d, required 1 0 0 0 0 0",
                     done, busy, pass_cnt, fail_cnt, fail_flag, first_fail);
        end
    endtask

    task automatic test_over_len;
        int n;
        for (int i = 3; i < 32; i++)
            write_vec(i, 32'h1000_0000 + 32'(i), 32'(i * 3), 32'(i), 5'(i), 1'b1);
        start_run(37);
        wait_done(200, n);
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL over_len_cycles: busy=%0d cycles, required 64", n);
        end
        checks++;
        if (pass_cnt !== 6'd32 || fail_cnt !== 6'd0 || test_reg_index !== 5'd31 || inst_out !== 0) begin
            errors++;
            $display("FAIL over_len_counts: pass=%0d fail=%0d idx=%0d inst=%h, required 32 0 31 0",
                     pass_cnt, fail_cnt, test_reg_index, inst_out);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        start_run(3);
        repeat (2) @(negedge clk);
        checks++;
        if (inst_out !== ti[1]) begin
            errors++;
            $display("FAIL mid_vec1: inst=%h, required %h", inst_out, ti[1]);
        end
        reset = 1'b1; start = 1'b1; run_len = 6'd3;
        vec_we = 1'b1; vec_addr = '0; vec_inst = 32'hDEAD_BEEF; vec_chk = 1'b0;
        @(negedge clk);
        checks++;
        if ({inst_out, data_out} !== 64'h0 || test_reg_index !== 0 || busy !== 0 ||
            done !== 0 || fail_flag !== 0 || pass_cnt !== 0 || fail_cnt !== 0) begin
            errors++;
            $display("FAIL reset_mid: inst=%h data=%h idx=%0d busy=%0b done=%0b flag=%0b p=%0d f=%0d, required all 0",
                     inst_out, data_out, test_reg_index, busy, done, fail_flag, pass_cnt, fail_cnt);
        end
        reset = 1'b0; start = 1'b0; vec_we = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 0 || done !== 0) begin
            errors++;
            $display("FAIL reset_idle: busy=%0b done=%0b, required 0 0", busy, done);
        end
        start_run(3);
        checks++;
        if (inst_out !== ti[0] || data_out !== td[0]) begin
            errors++;
            $display("FAIL restart_entry0: inst=%h data=%h, required %h %h",
                     inst_out, data_out, ti[0], td[0]);
        end
        wait_done(20, n);
        checks++;
        if (pass_cnt !== 6'd3 || fail_cnt !== 0) begin
            errors++;
            $display("FAIL restart_counts: pass=%0d fail=%0d, required 3 0", pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_step_ignore;
        int n;
        write_vec(1, ti[1], td[1], 32'h55, 5'd2, 1'b0);
        start_run(3);
        @(negedge clk);
        start = 1'b1; run_len = 6'd1;
        vec_we = 1'b1; vec_addr = '0; vec_inst = 32'hDEAD_BEEF; vec_din = 32'h0; vec_chk = 1'b0;
        @(negedge clk);
        start = 1'b0; vec_we = 1'b0;
        wait_done(20, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL ignore_len: remaining busy=%0d, required 4", n);
        end
        checks++;
        if (pass_cnt !== 6'd2 || fail_cnt !== 0 || fail_flag !== 0) begin
            errors++;
            $display("FAIL ignore_chk0: pass=%0d fail=%0d flag=%0b, required 2 0 0",
                     pass_cnt, fail_cnt, fail_flag);
        end
        start_run(3);
        checks++;
        if (inst_out !== ti[0] || data_out !== td[0]) begin
            errors++;
            $display("FAIL ignore_we: inst=%h data=%h, required %h %h",
                     inst_out, data_out, ti[0], td[0]);
        end
        wait_done(20, n);
    endtask

    initial begin
        ti[0] = 32'h2021_0001; ti[1] = 32'h0021_1020; ti[2] = 32'h3463_0003;
        td[0] = 32'h11;        td[1] = 32'h22;        td[2] = 32'h33;
        reset = 1'b1; vec_we = 1'b0; vec_addr = '0; vec_inst = '0; vec_din = '0;
        vec_exp = '0; vec_idx = '0; vec_chk = 1'b0; start = 1'b0; run_len = '0;
        bad_on = 1'b0; bad_idx = '0;
        test_reset();
        test_basic_run();
        test_fail_vec();
        test_zero_len();
        test_over_len();
        test_reset_mid();
        test_step_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
